// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue between fetch and decode.
// An entry is a {pc, instr} pair; the decode-side bus reuses the same type.
package fetch_queue_pkg;

    // One buffered fetch result.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // addi x0, x0, 0: presented to decode whenever no real entry is available.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x fetch_entry_t register array
// with one synchronous write port and one combinational read port.
// The array has no reset; validity is tracked entirely by the queue's count.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [PTR_W-1:0]   wr_addr,
    input  fetch_entry_t       wr_data,
    input  logic [PTR_W-1:0]   rd_addr,
    output fetch_entry_t       rd_data
);

    fetch_entry_t mem [DEPTH];

    // Write the pushed entry into its slot on the rising edge.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Head entry is read combinationally so it falls through to decode.
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// First-word-fall-through FIFO between fetch and decode.
// Stalls fetch when full, discards everything on a taken-branch flush.
// Optional macro FETCHQ_BYPASS_EN: when the queue is empty, a push is shown
// on pop_* in the same cycle and, if decode accepts it, never gets stored.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_instr,
    input  logic             flush,
    input  logic             pop_ready,
    output logic             fetch_stall,
    output logic             pop_valid,
    output logic [31:0]      pop_pc,
    output logic [31:0]      pop_instr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic             queue_valid;
    logic             push_do;
    logic             pop_do;
    logic             mem_wr_en;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head_entry;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (head_entry)
    );

    // Stall comes straight from the registered count so fetch never sees a
    // combinational path from its own push_valid.
    always_comb begin
        fetch_stall = (count_q == FULL_COUNT);
        queue_valid = (count_q != '0);
        wr_entry    = '{pc: push_pc, instr: push_instr};
    end

    // Decide which handshakes actually move data this cycle; a bypassed
    // entry that decode takes immediately is not stored at all.
    always_comb begin
        push_do = push_valid && !fetch_stall;
        pop_do  = queue_valid && pop_ready;
`ifdef FETCHQ_BYPASS_EN
        if (!queue_valid && push_valid && !flush && pop_ready) begin
            push_do = 1'b0;
        end
`endif
        mem_wr_en = push_do && !flush;
    end

    // Drive the decode-side bus from the head slot, or the empty defaults.
    always_comb begin
        pop_valid = queue_valid;
        pop_pc    = queue_valid ? head_entry.pc    : 32'h0;
        pop_instr = queue_valid ? head_entry.instr : NOP_INSTR;
`ifdef FETCHQ_BYPASS_EN
        if (!queue_valid && push_valid && !flush) begin
            pop_valid = 1'b1;
            pop_pc    = push_pc;
            pop_instr = push_instr;
        end
`endif
    end

    // Pointer and occupancy bookkeeping; flush wins over any push or pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_do) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_do) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_do, pop_do})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Occupancy is exported directly for debug and performance counters.
    always_comb begin
        count = count_q;
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A queue-based reference model tracks
// the expected contents; a compare process checks every cycle, and directed
// sequences add hand-computed literal checks.
`timescale 1ns/100ps
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clock      = 1'b0;
    logic        reset      = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_pc    = 32'h0;
    logic [31:0] push_instr = 32'h0;
    logic        flush      = 1'b0;
    logic        pop_ready  = 1'b0;
    logic        fetch_stall;
    logic        pop_valid;
    logic [31:0] pop_pc;
    logic [31:0] pop_instr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_entry_t model_q[$];
    logic [31:0]  popped[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_pc     (push_pc),
        .push_instr  (push_instr),
        .flush       (flush),
        .pop_ready   (pop_ready),
        .fetch_stall (fetch_stall),
        .pop_valid   (pop_valid),
        .pop_pc      (pop_pc),
        .pop_instr   (pop_instr),
        .count       (count)
    );

    initial begin
        forever #10 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge so they are stable around posedge.
    task automatic applyStimulus(input logic pv, input logic [31:0] pc,
                                 input logic fl, input logic pr);
        @(negedge clock);
        push_valid = pv;
        push_pc    = pc;
        push_instr = 32'h0010_0093 + pc;
        flush      = fl;
        pop_ready  = pr;
    endtask

    // Reference model: FIFO semantics applied at each rising edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            int  size_now;
            bit  bypass_take;
            bit  do_pop;
            bit  do_push;
            size_now    = model_q.size();
            bypass_take = 1'b0;
`ifdef FETCHQ_BYPASS_EN
            bypass_take = (size_now == 0) && push_valid && pop_ready;
`endif
            do_pop  = (size_now != 0) && pop_ready;
            do_push = push_valid && (size_now < DEPTH) && !bypass_take;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{pc: push_pc, instr: push_instr});
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            logic        exp_valid;
            logic [31:0] exp_pc;
            logic [31:0] exp_instr;
            int          size_now;
            @(negedge clock);
            #2;
            size_now  = model_q.size();
            exp_valid = (size_now != 0);
            exp_pc    = (size_now != 0) ? model_q[0].pc : 32'h0;
            exp_instr = (size_now != 0) ? model_q[0].instr : NOP_INSTR;
`ifdef FETCHQ_BYPASS_EN
            if (size_now == 0 && push_valid && !flush && !reset) begin
                exp_valid = 1'b1;
                exp_pc    = push_pc;
                exp_instr = push_instr;
            end
`endif
            checkOutput("cyc_count", 32'(count), 32'(size_now));
            checkOutput("cyc_stall", 32'(fetch_stall), 32'(size_now == DEPTH));
            checkOutput("cyc_valid", 32'(pop_valid), 32'(exp_valid));
            checkOutput("cyc_pc", pop_pc, exp_pc);
            checkOutput("cyc_instr", pop_instr, exp_instr);
        end
    end

    initial begin
        int          idx;
        logic        toggle;
        logic [31:0] drain_pcs [4];
        #1 reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #4 reset = 1'b0;

        // Idle after reset.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_valid", 32'(pop_valid), 32'd0);
        checkOutput("rst_instr", pop_instr, 32'h0000_0013);
        checkOutput("rst_pc", pop_pc, 32'h0);
        checkOutput("rst_stall", 32'(fetch_stall), 32'd0);

        // Fill to full, attempt a fifth push, then drain in order.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
        #3;
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_stall", 32'(fetch_stall), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("full_ignore_count", 32'(count), 32'd4);
        drain_pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            #3;
            checkOutput("drain_pc", pop_pc, drain_pcs[i]);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("drain_empty", 32'(count), 32'd0);

        // Wrap-around stream with toggling pop_ready.
        idx    = 0;
        toggle = 1'b1;
        popped.delete();
        for (int c = 0; c < 40 && idx < 10; c++) begin
            applyStimulus(1'b1, 32'h200 + 32'(idx * 4), 1'b0, toggle);
            #3;
            if (pop_valid && pop_ready) popped.push_back(pop_pc);
            checkOutput("wrap_count_le4", 32'(count <= 3'd4), 32'd1);
            if (!fetch_stall) idx++;
            toggle = ~toggle;
        end
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            #3;
            if (pop_valid) popped.push_back(pop_pc);
        end
        checkOutput("wrap_total", 32'(popped.size()), 32'd10);
        for (int i = 0; i < popped.size() && i < 10; i++) begin
            checkOutput("wrap_order", popped[i], 32'h200 + 32'(i * 4));
        end

        // Flush with three entries plus a simultaneous push.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_valid", 32'(pop_valid), 32'd0);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("flush_next_pc", pop_pc, 32'h40);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

        // Full with simultaneous pop: slot freed, stall clears next cycle.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h510, 1'b0, 1'b1);
        #3;
        checkOutput("fullpop_stall_now", 32'(fetch_stall), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("fullpop_count", 32'(count), 32'd3);
        checkOutput("fullpop_stall_next", 32'(fetch_stall), 32'd0);
        checkOutput("fullpop_head", pop_pc, 32'h504);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

        // Push into an empty queue while decode is ready.
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        #3;
`ifdef FETCHQ_BYPASS_EN
        checkOutput("byp_valid", 32'(pop_valid), 32'd1);
        checkOutput("byp_pc", pop_pc, 32'h100);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("byp_count", 32'(count), 32'd0);
`else
        checkOutput("nobyp_valid", 32'(pop_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("nobyp_pc_next", pop_pc, 32'h100);
        checkOutput("nobyp_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
`endif

        // Asynchronous reset mid-burst with three entries held.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h600 + 32'(i * 4), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h60C, 1'b0, 1'b0);
        #3;
        checkOutput("mid_count", 32'(count), 32'd3);
        #2 reset = 1'b1;
        #1;
        push_valid = 1'b0;
        checkOutput("async_count", 32'(count), 32'd0);
        checkOutput("async_valid", 32'(pop_valid), 32'd0);
        checkOutput("async_instr", pop_instr, 32'h0000_0013);
        @(negedge clock);
        #4 reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("post_rst_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_queue
